// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path (and a future transmitter).
//   rx_state_e : receiver FSM states
//   DATA_BITS  : payload bits per frame (8N1)
//   half_bit() : clock count to the middle of a bit period
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

  localparam int DATA_BITS = 8;

  // Cycles from the start-bit falling edge to mid-bit (integer division).
  function automatic logic [15:0] half_bit(input int clks_per_bit);
    return 16'(clks_per_bit / 2);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchroniser for an asynchronous serial line.
// Flops reset to 1 (line idle level) so a reset never looks like a start bit.
//   clk      : sampling clock
//   rst      : asynchronous active-high reset
//   rx_async : raw asynchronous input
//   rx_s     : synchronised output, SYNC_STAGES cycles behind rx_async
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_async,
  output logic rx_s
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '1;
    else     chain <= {chain[SYNC_STAGES-2:0], rx_async};
  end

  assign rx_s = chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_char.sv
// 8N1 serial byte receiver with a one-byte valid/ready holding register.
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   rx_serial : asynchronous serial input, idle high
//   out_char  : received byte (held while out_valid and not consumed)
//   out_valid : out_char holds an unconsumed byte
//   out_ready : consumer accepts the byte when high with out_valid
//   frame_err : one-cycle pulse, stop bit sampled low
//   overrun   : one-cycle pulse, good byte dropped because holding reg full
//   busy      : FSM not in IDLE
module uart_rx_char
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_serial,
  output logic [7:0] out_char,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = half_bit(CLKS_PER_BIT) - 16'd1;
  localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_e            state, state_nx;
  logic [15:0]          cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;

  // FSM-derived strobes
  logic cnt_run, bit_tick, good_stop, bad_stop;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .rx_async (rx_serial),
    .rx_s     (rx_s)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (!rx_s) state_nx = START;
      // Mid-start sample: a high line means the falling edge was a glitch.
      START: if (cnt == HALF_LAST) state_nx = rx_s ? IDLE : DATA;
      DATA:  if (cnt == BIT_LAST && bit_cnt == LAST_BIT) state_nx = STOP;
      STOP:  if (cnt == BIT_LAST) state_nx = rx_s ? IDLE : BREAK;
      // Held-low line: wait for idle so a break yields one frame_err only.
      BREAK: if (rx_s) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output / strobe decode
  always_comb begin
    busy      = (state != IDLE);
    cnt_run   = (state == START) || (state == DATA) || (state == STOP);
    bit_tick  = (state == DATA) && (cnt == BIT_LAST);
    good_stop = (state == STOP) && (cnt == BIT_LAST) && rx_s;
    bad_stop  = (state == STOP) && (cnt == BIT_LAST) && !rx_s;
  end

  // Counters, shift register and holding register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      out_char  <= 8'h00;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad_stop;
      // A consume in the stop-sample cycle frees the register for the new byte.
      overrun   <= good_stop && out_valid && !out_ready;

      // Counter restarts on every state change and at each data-bit boundary.
      if (state != state_nx || bit_tick) cnt <= '0;
      else if (cnt_run)                  cnt <= cnt + 16'd1;
      else                               cnt <= '0;

      if (state == START)  bit_cnt <= '0;
      else if (bit_tick)   bit_cnt <= bit_cnt + 3'd1;

      if (bit_tick) shift[bit_cnt] <= rx_s;

      if (good_stop && (!out_valid || out_ready)) begin
        out_char  <= shift;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_char.sv
module tb_uart_rx_char;

  localparam int C = 16;

  logic       clk = 0;
  logic       rst;
  logic       rx_serial;
  logic [7:0] out_char;
  logic       out_valid;
  logic       out_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx_char #(.CLKS_PER_BIT(C), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_serial (rx_serial),
    .out_char  (out_char),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state: bytes the consumer must see, in order, and expected flag counts.
  logic [7:0] exp_q[$];
  int exp_fe = 0, exp_ov = 0;

  // Observed activity.
  int fe_cnt = 0, ov_cnt = 0, busy_cnt = 0, n_deliv = 0;
  int t_valid = 0, t_start = 0;
  logic [7:0] last_char = 8'h00;
  logic valid_d = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] to_upper(input logic [7:0] c);
    return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
  endfunction

  // Frame-level model: a good frame is either queued for the consumer or,
  // if the consumer is stalled with a byte already waiting, counted as overrun.
  task automatic model_frame(input logic [7:0] b, input logic good);
    if (!good)                               exp_fe++;
    else if (!out_ready && exp_q.size() > 0) exp_ov++;
    else                                     exp_q.push_back(b);
  endtask

  task automatic hold(input logic v, input int n);
    rx_serial = v;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    model_frame(b, stop);
    t_start = cyc;
    hold(1'b0, C);
    for (int i = 0; i < 8; i++) hold(b[i], C);
    hold(stop, C);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin @(posedge clk); #1; n++; end
    chk({name, "_drain"}, exp_q.size(), 0);
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outputs", 32'({out_char, out_valid, frame_err, overrun, busy}), 0);
      valid_d = 0;
    end else begin
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
      if (busy)      busy_cnt++;
      if (out_valid && !valid_d) t_valid = cyc;
      valid_d = out_valid;
      if (out_valid) begin
        if (exp_q.size() == 0) chk("valid_without_expected_byte", 32'(out_valid), 0);
        else begin
          chk("out_char", 32'(out_char), 32'(exp_q[0]));
          if (out_ready) begin
            last_char = out_char;
            n_deliv++;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int fe0, ov0, d0;
    rst = 1; rx_serial = 1; out_ready = 1;
    repeat (4) begin @(posedge clk); #1; end
    rst = 0;
    hold(1'b1, 10);

    // 1: single 'a'
    send_frame(8'h61, 1'b1);
    hold(1'b1, 20);
    drain("t1");
    chk("t1_latency_in_window", 32'((t_valid - t_start) >= 154 && (t_valid - t_start) <= 156), 1);
    chk("t1_char", 32'(last_char), 32'h61);
    chk("t1_to_upper", 32'(to_upper(last_char)), 32'h41);
    chk("t1_frame_err", 32'(fe_cnt), 0);
    chk("t1_overrun", 32'(ov_cnt), 0);

    // 2: start glitch
    busy_cnt = 0; d0 = n_deliv;
    hold(1'b0, 4);
    hold(1'b1, 30);
    chk("t2_busy_bounded", 32'(busy_cnt > 0 && busy_cnt <= 8), 1);
    chk("t2_no_delivery", 32'(n_deliv - d0), 0);
    chk("t2_no_flags", 32'(fe_cnt + ov_cnt), 0);

    // 3: bad stop then break, then recovery
    fe0 = fe_cnt;
    send_frame(8'h48, 1'b0);
    hold(1'b0, 40);
    hold(1'b1, 20);
    chk("t3_one_frame_err", 32'(fe_cnt - fe0), 1);
    chk("t3_frame_err_model", 32'(fe_cnt), 32'(exp_fe));
    send_frame(8'h7A, 1'b1);
    hold(1'b1, 20);
    drain("t3");
    chk("t3_recovered_char", 32'(last_char), 32'h7A);

    // 4: overrun with stalled consumer
    ov0 = ov_cnt;
    out_ready = 0;
    send_frame(8'h28, 1'b1);
    hold(1'b1, 10);
    send_frame(8'hB7, 1'b1);
    hold(1'b1, 20);
    chk("t4_held_valid", 32'(out_valid), 1);
    chk("t4_held_char", 32'(out_char), 32'h28);
    chk("t4_one_overrun", 32'(ov_cnt - ov0), 1);
    chk("t4_overrun_model", 32'(ov_cnt), 32'(exp_ov));
    out_ready = 1;
    hold(1'b1, 3);
    chk("t4_consumed_valid", 32'(out_valid), 0);
    chk("t4_consumed_char", 32'(last_char), 32'h28);
    chk("t4_queue_empty", exp_q.size(), 0);

    // 5: back-to-back frames
    d0 = n_deliv;
    send_frame(8'h41, 1'b1);
    send_frame(8'h7A, 1'b1);
    send_frame(8'h7B, 1'b1);
    hold(1'b1, 20);
    drain("t5");
    chk("t5_three_delivered", 32'(n_deliv - d0), 3);
    chk("t5_last_char", 32'(last_char), 32'h7B);

    // 6: reset during data bit 4 of 0x6D
    d0 = n_deliv;
    hold(1'b0, C);
    for (int i = 0; i < 4; i++) hold(logic'((8'h6D >> i) & 8'h01), C);
    hold(1'b0, C / 2);
    rst = 1; rx_serial = 1;
    exp_q.delete();
    hold(1'b1, 5);
    rst = 0;
    hold(1'b1, 10);
    send_frame(8'h30, 1'b1);
    hold(1'b1, 20);
    drain("t6");
    chk("t6_only_one", 32'(n_deliv - d0), 1);
    chk("t6_char", 32'(last_char), 32'h30);
    chk("final_frame_err_model", 32'(fe_cnt), 32'(exp_fe));
    chk("final_overrun_model", 32'(ov_cnt), 32'(exp_ov));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/uart_rx_char.md
Name: uart_rx_char

Overview:
- Serial byte receiver sitting directly upstream of the toUpper case converter.
- Recovers 8N1 asynchronous serial frames (1 start, 8 data LSB-first, 1 stop, no parity) from a single rx line.
- Presents each received byte on an 8-bit valid/ready output whose data bus drives toUpper's in_char.
- Flags framing errors and overruns.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit period; legal range 4..65535.
- SYNC_STAGES, 2, flip-flop stages in the rx input synchroniser; legal range 2..4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_serial  in  1  asynchronous serial input; idle level 1.
- out_char  out  8  received byte; feeds toUpper in_char.
- out_valid  out  1  out_char holds an unconsumed byte.
- out_ready  in  1  consumer accepts the byte when high together with out_valid.
- frame_err  out  1  one-cycle pulse: stop bit sampled as 0.
- overrun  out  1  one-cycle pulse: a good byte was dropped because the holding register was full.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values:
  - out_char=8'h00, out_valid=0, frame_err=0, overrun=0, busy=0.
  - Synchroniser flops reset to 1; FSM resets to IDLE; bit and clock counters reset to 0.
- Reset asserted mid-frame discards the partial byte and any held byte. After release the FSM waits in IDLE for the next falling edge.
- Synchroniser: rx_serial passes through SYNC_STAGES flops. All decisions use the synchronised rx_s.
- Clock counter: 16-bit, counts 0..CLKS_PER_BIT-1. Bit counter: 3-bit.
- FSM states:
  - IDLE:
    - rx_s==0 -> START with clock counter=0.
  - START:
    - At count CLKS_PER_BIT/2-1 (integer division), sample rx_s.
    - If 0 -> DATA with counters=0.
    - If 1 -> IDLE (glitch rejected; no flags).
  - DATA:
    - At count CLKS_PER_BIT-1, shift rx_s into bit[bit counter] (LSB first) and reset the clock counter.
    - After bit 7 -> STOP.
  - STOP:
    - At count CLKS_PER_BIT-1, sample rx_s.
    - If 1 -> deliver the byte and go to IDLE.
    - If 0 -> pulse frame_err, discard the byte, go to BREAK.
  - BREAK:
    - Remain until rx_s==1, then IDLE.
    - A continuous-low line raises exactly one frame_err.
- Delivery, in the cycle after the good stop sample:
  - If out_valid==0, or out_valid&&out_ready in the stop-sample cycle: load out_char and set out_valid=1.
  - Otherwise keep the old byte and pulse overrun for 1 cycle. The new byte is lost.
- Handshake:
  - out_valid drops on the cycle after out_valid&&out_ready, unless a new byte loads that same edge, in which case it stays high.
  - out_char is stable while out_valid=1 and not consumed.
- Latency: falling edge of the start bit at the rx_serial pin to out_valid high is SYNC_STAGES + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles, ±1 for edge alignment.
- Back-to-back frames: a start bit immediately following the stop sample is detected from IDLE with no dead cycle beyond the single IDLE evaluation.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, STOP, BREAK).
  - DATA_BITS=8.
  - function half_bit(CLKS_PER_BIT).
- Sub-module uart_rx_sync: parameterised SYNC_STAGES flop chain with asynchronous reset to 1. Reused by a future transmitter loopback.
- Top level holds the FSM, counters, shift register and output holding register.

Test Plan (CLKS_PER_BIT=16, SYNC_STAGES=2):
- Single frame 0x61 ('a'), out_ready=1 -> out_valid pulses 1 cycle with out_char=0x61. Downstream toUpper yields 0x41. frame_err=overrun=0.
- Start glitch: rx low for 4 cycles, then high -> FSM returns to IDLE. No out_valid, no flags; busy high for at most 8 cycles.
- Frame 0x48 with stop bit driven 0, then line held low for 40 cycles -> exactly one frame_err pulse, no out_valid. After rx returns high, frame 0x7A is received correctly.
- out_ready=0; send 0x28 then 0xB7 -> out_char stays 0x28 with out_valid=1, and one overrun pulse at the 0xB7 stop. Raise out_ready -> 0x28 consumed, out_valid=0.
- Back-to-back frames 0x41, 0x7A, 0x7B with out_ready=1 and no idle gap -> three out_valid pulses in order: 0x41, 0x7A, 0x7B.
- Assert rst during data bit 4 of frame 0x6D, release, then send 0x30 -> all outputs 0 during reset. Only 0x30 is delivered.
